// File: rtl/hazard_control_unit.sv
// Hazard controller for the five-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, multi-cycle EX wait states and a stall-cycle counter.
module hazard_control_unit #(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  IDRs,
    input  logic [4:0]  IDRt,
    input  logic        IDUsesRs,
    input  logic        IDUsesRt,
    input  logic        EXMemRead,
    input  logic [4:0]  EXRd,
    input  logic        BranchTaken,
    input  logic        MultiCycleStart,
    output logic        PCWriteIn,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXWrite,
    output logic        IDEXFlush,
    output logic        EXMEMBubble,
    output logic        Busy,
    output logic [31:0] StallCycles
);

    typedef enum logic {
        RUN,
        MC_WAIT
    } hazardState;

    // A latency of one finishes inside the start cycle, so no wait is needed
    localparam bit         MC_STALLS = (MC_LATENCY > 1);
    localparam logic [7:0] MC_RELOAD = 8'(MC_LATENCY - 1);

    hazardState  state;
    hazardState  nextState;
    logic [7:0]  waitCount;
    logic [7:0]  nextWaitCount;
    logic [31:0] stallCount;
    logic        loadUse;

    assign loadUse = EXMemRead && (EXRd != 5'd0) &&
                     ((IDUsesRs && (IDRs == EXRd)) || (IDUsesRt && (IDRt == EXRd)));

    assign StallCycles = stallCount;

    // Next-state and control outputs; branch beats multi-cycle start beats load-use
    always_comb begin
        nextState     = state;
        nextWaitCount = waitCount;
        PCWriteIn     = 1'b1;
        IFIDWrite     = 1'b1;
        IFIDFlush     = 1'b0;
        IDEXWrite     = 1'b1;
        IDEXFlush     = 1'b0;
        EXMEMBubble   = 1'b0;
        Busy          = 1'b0;
        if (!Reset) begin
            unique case (state)
                RUN: begin
                    if (BranchTaken) begin
                        IFIDFlush = 1'b1;
                        IDEXFlush = 1'b1;
                    end else if (MultiCycleStart) begin
                        if (MC_STALLS) begin
                            PCWriteIn     = 1'b0;
                            IFIDWrite     = 1'b0;
                            IDEXWrite     = 1'b0;
                            EXMEMBubble   = 1'b1;
                            nextState     = MC_WAIT;
                            nextWaitCount = MC_RELOAD;
                        end
                    end else if (loadUse) begin
                        PCWriteIn = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end
                end
                MC_WAIT: begin
                    PCWriteIn     = 1'b0;
                    IFIDWrite     = 1'b0;
                    IDEXWrite     = 1'b0;
                    EXMEMBubble   = 1'b1;
                    Busy          = 1'b1;
                    nextWaitCount = waitCount - 8'd1;
                    if (waitCount <= 8'd1) begin
                        nextState = RUN;
                    end
                end
                default: begin
                    nextState = RUN;
                end
            endcase
        end
    end

    // State, wait counter and free-running stall counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= RUN;
            waitCount  <= 8'd0;
            stallCount <= 32'd0;
        end else begin
            state      <= nextState;
            waitCount  <= nextWaitCount;
            stallCount <= stallCount + {31'd0, ~PCWriteIn};
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized self-checking bench for hazard_control_unit, exercising
// MC_LATENCY=4 and MC_LATENCY=1 instances side by side against a reference model.
module tb_hazard_control_unit;

    logic        Clk;
    logic        Reset;
    logic [4:0]  IDRs;
    logic [4:0]  IDRt;
    logic        IDUsesRs;
    logic        IDUsesRt;
    logic        EXMemRead;
    logic [4:0]  EXRd;
    logic        BranchTaken;
    logic        MultiCycleStart;

    // Control bits packed as {PCWriteIn, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMBubble, Busy}
    logic [6:0]  ctl0;
    logic [6:0]  ctl1;
    logic [31:0] stl0;
    logic [31:0] stl1;

    int          vectorCount = 0;
    int          missCount   = 0;

    // Reference model: remaining frozen cycles and stall tally per instance
    int          mLeft [2];
    logic [31:0] mStall [2];

    hazard_control_unit #(.MC_LATENCY(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXRd(EXRd),
        .BranchTaken(BranchTaken), .MultiCycleStart(MultiCycleStart),
        .PCWriteIn(ctl0[6]), .IFIDWrite(ctl0[5]), .IFIDFlush(ctl0[4]),
        .IDEXWrite(ctl0[3]), .IDEXFlush(ctl0[2]), .EXMEMBubble(ctl0[1]),
        .Busy(ctl0[0]), .StallCycles(stl0)
    );

    hazard_control_unit #(.MC_LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXRd(EXRd),
        .BranchTaken(BranchTaken), .MultiCycleStart(MultiCycleStart),
        .PCWriteIn(ctl1[6]), .IFIDWrite(ctl1[5]), .IFIDFlush(ctl1[4]),
        .IDEXWrite(ctl1[3]), .IDEXFlush(ctl1[2]), .EXMEMBubble(ctl1[1]),
        .Busy(ctl1[0]), .StallCycles(stl1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRs, input logic usesRt, input logic memRead,
                                 input logic [4:0] rd, input logic br, input logic mcs);
        @(negedge Clk);
        Reset           = rst;
        IDRs            = rs;
        IDRt            = rt;
        IDUsesRs        = usesRs;
        IDUsesRt        = usesRt;
        EXMemRead       = memRead;
        EXRd            = rd;
        BranchTaken     = br;
        MultiCycleStart = mcs;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic loadUseHit();
        applyStimulus(1'b0, 5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    endtask

    // Compare both instances against the model mid-cycle, then advance the model past the posedge
    always @(negedge Clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            int unsigned lat;
            logic lu, p, fw, ff, ew, ef, bb, by;
            lat = (i == 0) ? 4 : 1;
            lu  = EXMemRead && (EXRd != 5'd0) &&
                  ((IDUsesRs && (IDRs == EXRd)) || (IDUsesRt && (IDRt == EXRd)));
            p = 1; fw = 1; ff = 0; ew = 1; ef = 0; bb = 0; by = 0;
            if (Reset) begin
                // defaults
            end else if (mLeft[i] > 0) begin
                p = 0; fw = 0; ew = 0; bb = 1; by = 1;
            end else if (BranchTaken) begin
                ff = 1; ef = 1;
            end else if (MultiCycleStart) begin
                if (lat > 1) begin
                    p = 0; fw = 0; ew = 0; bb = 1;
                end
            end else if (lu) begin
                p = 0; fw = 0; ef = 1;
            end
            if (i == 0) begin
                checkOutput("ctl4", {25'd0, ctl0}, {25'd0, p, fw, ff, ew, ef, bb, by});
                checkOutput("stall4", stl0, mStall[0]);
            end else begin
                checkOutput("ctl1", {25'd0, ctl1}, {25'd0, p, fw, ff, ew, ef, bb, by});
                checkOutput("stall1", stl1, mStall[1]);
            end
            if (Reset) begin
                mLeft[i]  = 0;
                mStall[i] = 32'd0;
            end else begin
                mStall[i] = mStall[i] + (p ? 32'd0 : 32'd1);
                if (mLeft[i] > 0) begin
                    mLeft[i] = mLeft[i] - 1;
                end else if (!BranchTaken && MultiCycleStart && lat > 1) begin
                    mLeft[i] = int'(lat) - 1;
                end
            end
        end
    end

    initial begin
        mLeft[0] = 0; mLeft[1] = 0;
        mStall[0] = 32'd0; mStall[1] = 32'd0;
        Reset = 1'b1; IDRs = 5'd0; IDRt = 5'd0; IDUsesRs = 1'b0; IDUsesRt = 1'b0;
        EXMemRead = 1'b0; EXRd = 5'd0; BranchTaken = 1'b0; MultiCycleStart = 1'b0;

        // Reset holds defaults even with a load-use match and a multi-cycle start
        applyStimulus(1'b1, 5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        #3 checkOutput("resetCtl", {25'd0, ctl0}, 32'h68);
        idle();
        #3 checkOutput("resetStall", stl0, 32'd0);

        // Load-use stall for one cycle
        loadUseHit();
        #3 checkOutput("loadUseCtl", {25'd0, ctl0}, 32'h0C);
        idle();
        #3 checkOutput("loadUseStall", stl0, 32'd1);

        // $zero destination and unused rt never stall
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #3 checkOutput("zeroReg", {31'd0, ctl0[6]}, 32'd1);
        applyStimulus(1'b0, 5'd4, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        #3 checkOutput("unusedRt", {31'd0, ctl0[6]}, 32'd1);

        // Branch overrides a simultaneous load-use
        applyStimulus(1'b0, 5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        #3 checkOutput("branchCtl", {25'd0, ctl0}, 32'h7C);
        idle();
        #3 checkOutput("branchStall", stl0, 32'd1);

        // Multi-cycle op: 4-cycle freeze on dut4, no freeze on dut1
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #3 checkOutput("mcStart4", {25'd0, ctl0}, 32'h02);
        checkOutput("mcStart1", {25'd0, ctl1}, 32'h68);
        for (int c = 2; c <= 4; c++) begin
            idle();
            #3 checkOutput("mcWait4", {25'd0, ctl0}, 32'h03);
        end
        idle();
        #3 checkOutput("mcDone4", {25'd0, ctl0}, 32'h68);
        checkOutput("mcStall4", stl0, 32'd5);
        checkOutput("mcStall1", stl1, 32'd1);

        // Reset in the second wait cycle aborts the freeze
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #3 checkOutput("midResetCtl", {25'd0, ctl0}, 32'h68);
        idle();
        #3 checkOutput("afterResetCtl", {25'd0, ctl0}, 32'h68);
        checkOutput("afterResetStall", stl0, 32'd0);

        // Counter wrap: preload near the top, then three load-use stalls
        @(negedge Clk);
        force dut4.stallCount = 32'hFFFF_FFFE;
        mStall[0] = 32'hFFFF_FFFE;
        Reset = 1'b0; IDRs = 5'd8; IDRt = 5'd3; IDUsesRs = 1'b1; IDUsesRt = 1'b0;
        EXMemRead = 1'b1; EXRd = 5'd8; BranchTaken = 1'b0; MultiCycleStart = 1'b0;
        #1 release dut4.stallCount;
        #2 checkOutput("wrap0", stl0, 32'hFFFF_FFFE);
        loadUseHit();
        #3 checkOutput("wrap1", stl0, 32'hFFFF_FFFF);
        loadUseHit();
        #3 checkOutput("wrap2", stl0, 32'h0000_0000);
        idle();
        #3 checkOutput("wrap3", stl0, 32'h0000_0001);

        // Randomized traffic with hazards made likely by a small register range
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end
        idle();
        @(negedge Clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the five-stage MIPS datapath. It sits upstream of the program counter and the IF/ID and ID/EX pipeline registers, and drives their write-enable and flush controls, including PCWriteIn of the PC register. It covers three cases: load-use stalls, taken-branch flushes, and multi-cycle EX operations (mul/div), which need a counter-based wait state. It also keeps a free-running count of stall cycles for performance measurement.

## Interface
- MC_LATENCY, 4, total EX cycles of a multi-cycle op; legal range 1..255
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- IDRs  in  5  rs field of the instruction in ID
- IDRt  in  5  rt field of the instruction in ID
- IDUsesRs  in  1  ID instruction reads rs
- IDUsesRt  in  1  ID instruction reads rt
- EXMemRead  in  1  instruction in EX is a load
- EXRd  in  5  destination register of the instruction in EX
- BranchTaken  in  1  branch/jump resolved taken in EX this cycle
- MultiCycleStart  in  1  multi-cycle op is in EX this cycle; single-cycle pulse
- PCWriteIn  out  1  PC load enable
- IFIDWrite  out  1  IF/ID register load enable
- IFIDFlush  out  1  IF/ID register load NOP
- IDEXWrite  out  1  ID/EX register load enable
- IDEXFlush  out  1  ID/EX register load bubble (all control zero)
- EXMEMBubble  out  1  EX/MEM register load bubble
- Busy  out  1  state is MC_WAIT
- StallCycles  out  32  count of cycles with PCWriteIn=0

## Operation
- States: RUN and MC_WAIT. State and StallCycles are registered. Control outputs are combinational from the state and the inputs.
- Default outputs in RUN with no hazard: PCWriteIn=1, IFIDWrite=1, IDEXWrite=1, IFIDFlush=0, IDEXFlush=0, EXMEMBubble=0.
- Load-use condition (RUN only): EXMemRead && EXRd!=0 && ((IDUsesRs && IDRs==EXRd) || (IDUsesRt && IDRt==EXRd)).
  - Response: PCWriteIn=0, IFIDWrite=0, IDEXFlush=1.
- Taken branch (RUN only): PCWriteIn=1, IFIDFlush=1, IDEXFlush=1.
  - Overrides load-use; no stall that cycle.
- Multi-cycle start (RUN, MultiCycleStart=1, BranchTaken=0):
  - Outputs this cycle: PCWriteIn=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1.
  - If MC_LATENCY>1, load count=MC_LATENCY-1 and go to MC_WAIT.
  - If MC_LATENCY==1, no stall, no state change, default outputs.
  - Load-use outputs are suppressed in this cycle.
- MC_WAIT:
  - Outputs: PCWriteIn=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1, Busy=1. Flushes are 0.
  - All hazard inputs are ignored, because EX is frozen and its inputs are held.
  - Each cycle, count decrements. When count==1 in the current cycle, the next state is RUN.
- Simultaneous BranchTaken and MultiCycleStart cannot happen by construction. If it occurs, BranchTaken wins and MC_WAIT is not entered.
- StallCycles increments by 1 on every posedge where PCWriteIn was 0. It wraps from 0xFFFFFFFF to 0.
- Count width is 8 bits.

## Timing
- Reset: state=RUN, count=0, StallCycles=0.
  - While Reset=1, outputs take the RUN/no-hazard defaults and Busy=0, regardless of inputs.
- Reset asserted in MC_WAIT aborts the wait. The next cycle is RUN.
- Load-use stall lasts exactly 1 cycle. The next cycle the load has moved to MEM, so the condition clears naturally.
- Multi-cycle op: PCWriteIn=0 for exactly MC_LATENCY consecutive cycles, counting the start cycle. PCWriteIn returns to 1 in cycle MC_LATENCY+1.
- A branch flush takes effect at the posedge ending the cycle in which BranchTaken=1. PC loads the target on that same edge.
- All output decisions are combinational within a cycle. There is no added latency.

## Test plan
- Load-use: EXMemRead=1, EXRd=8, IDUsesRs=1, IDRs=8 for 1 cycle -> PCWriteIn=0, IFIDWrite=0, IDEXFlush=1 that cycle; StallCycles 0->1.
- $zero and unused operands: EXRd=0 matching IDRs=0, or IDRt match with IDUsesRt=0 -> no stall, defaults held, StallCycles unchanged.
- Branch priority: BranchTaken=1 together with a load-use match -> PCWriteIn=1, IFIDFlush=1, IDEXFlush=1; StallCycles unchanged.
- Multi-cycle op, MC_LATENCY=4: MultiCycleStart pulse -> PCWriteIn=0 and EXMEMBubble=1 for 4 cycles, Busy=1 for cycles 2-4, RUN on cycle 5; StallCycles +4. Repeat with MC_LATENCY=1 -> no stall.
- Reset mid-wait: Reset=1 in the 2nd MC_WAIT cycle -> next cycle RUN, Busy=0, StallCycles=0, PCWriteIn=1.
- Counter wrap: force StallCycles near 0xFFFFFFFE, then apply 3 load-use stalls -> reads 0xFFFFFFFF, 0x00000000, 0x00000001.
